// File: rtl/spi_readout_master_if.sv
// Signal bundle between the SPI readout master and its user / serial slave.
// start is a one-cycle-sampled request (no ready: it is taken only in IDLE, otherwise flagged as overrun); word_valid is a one-cycle strobe with no back-pressure.
interface spi_readout_master_if #(
   parameter int WIDTH = 12
);
   logic             start;
   logic             sdi;
   logic             sclk;
   logic             cs_n;
   logic [WIDTH-1:0] data_out;
   logic             word_valid;
   logic             busy;
   logic             overrun;
   logic [2:0]       dbg_state;

   modport master (
      input  start, sdi,
      output sclk, cs_n, data_out, word_valid, busy, overrun, dbg_state
   );

   modport slave (
      output start, sdi,
      input  sclk, cs_n, data_out, word_valid, busy, overrun, dbg_state
   );
endinterface

// File: rtl/spi_readout_master.sv
// SPI read master: generates sclk/cs_n from clk by division and assembles
// the slave's MSB-first bit stream into WIDTH-bit words.
module spi_readout_master #(
   parameter int WIDTH   = 12,
   parameter int CLK_DIV = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   spi_readout_master_if.master bus
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             sclk_q, sclk_d;
   logic             cs_n_q, cs_n_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             cnt_last;

   assign cnt_last = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      overrun_d = overrun_q;

      // A request outside IDLE is dropped but remembered until reset.
      if (bus.start && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            cs_n_d = 1'b1;
            if (bus.start) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         SETUP: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SHIFT: begin
            // sclk is low for one half-period after entry, so the first rise
            // lands a full half-period after the slave has driven its MSB.
            if (cnt_last) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  shift_d = {shift_q[WIDTH-2:0], bus.sdi};
               end else begin
                  bit_d = bit_q + BW'(1);
                  if (bit_q == BIT_LAST) begin
                     state_d = HOLD;
                  end
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            if (cnt_last) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               data_d  = shift_q;
               valid_d = 1'b1;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

   assign bus.sclk       = sclk_q;
   assign bus.cs_n       = cs_n_q;
   assign bus.data_out   = data_q;
   assign bus.word_valid = valid_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.overrun    = overrun_q;
   assign bus.dbg_state  = state_q;

endmodule
